// File: rtl/subleq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : subleq_pkg
// Brief    : Shared states, constants and IO_ID helper for the SUBLEQ core.
// Revision : 1.0
// ============================================================================
package subleq_pkg;

    localparam int INSTR_LEN = 3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FA    = 4'd1,
        ST_FB    = 4'd2,
        ST_FC    = 4'd3,
        ST_RA    = 4'd4,
        ST_RB    = 4'd5,
        ST_WB    = 4'd6,
        ST_IN_W  = 4'd7,
        ST_OUT_W = 4'd8,
        ST_EXEC  = 4'd9,
        ST_HALT  = 4'd10
    } core_state_t;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_SETUP = 2'd1,
        PS_WAIT  = 2'd2
    } port_state_t;

    // All-ones word of the given width, right-aligned in 32 bits
    function automatic logic [31:0] io_id(input int unsigned width);
        io_id = 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/subleq_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : subleq_mem_port
// Brief    : SETUP/WAIT sequencer for one req/ack memory transaction at a time.
// Revision : 1.0
// ============================================================================
module subleq_mem_port
    import subleq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    port_state_t       st_q, st_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= PS_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            st_q    <= st_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done    = 1'b0;
        case (st_q)
            PS_SETUP: begin
                st_d  = PS_WAIT;
                req_d = 1'b1;
            end
            PS_WAIT: begin
                if (mem_ack) begin
                    done  = 1'b1;
                    req_d = 1'b0;
                    st_d  = PS_IDLE;
                end
            end
            default: ;
        endcase
        // A new request may be chained on the completing cycle; req stays low for its SETUP
        if (start) begin
            st_d    = PS_SETUP;
            we_d    = wr;
            addr_d  = addr;
            wdata_d = wdata;
        end
    end

    assign rdata     = mem_rdata;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: rtl/subleq_core_p.sv
`default_nettype none
// ============================================================================
// Module   : subleq_core_p
// Brief    : Parametrised SUBLEQ core with req/ack memory, byte I/O and halt.
// Revision : 1.0
// ============================================================================
module subleq_core_p
    import subleq_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam logic [DATA_W-1:0] IO_ID = DATA_W'(io_id(DATA_W));

    core_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_a_q, ir_a_d;
    logic [DATA_W-1:0] ir_b_q, ir_b_d;
    logic [DATA_W-1:0] ir_c_q, ir_c_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              le_q, le_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              in_ready_q, in_ready_d;
    logic              halted_q, halted_d;

    logic              mp_start;
    logic              mp_wr;
    logic [ADDR_W-1:0] mp_addr;
    logic [DATA_W-1:0] mp_wdata;
    logic              mp_done;
    logic [DATA_W-1:0] mp_rdata;

    logic [DATA_W-1:0] diff;
    logic [ADDR_W-1:0] pc_next;
    logic              is_in;
    logic              is_out;

    subleq_mem_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mp_start),
        .wr        (mp_wr),
        .addr      (mp_addr),
        .wdata     (mp_wdata),
        .done      (mp_done),
        .rdata     (mp_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            ir_a_q      <= '0;
            ir_b_q      <= '0;
            ir_c_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            le_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_a_q      <= ir_a_d;
            ir_b_q      <= ir_b_d;
            ir_c_q      <= ir_c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            le_q        <= le_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_a_d      = ir_a_q;
        ir_b_d      = ir_b_q;
        ir_c_d      = ir_c_q;
        a_d         = a_q;
        b_d         = b_q;
        le_d        = le_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        halted_d    = halted_q;
        mp_start    = 1'b0;
        mp_wr       = 1'b0;
        mp_addr     = pc_q;
        mp_wdata    = '0;
        diff        = b_q - a_q;
        pc_next     = pc_q + ADDR_W'(INSTR_LEN);
        is_in       = (ir_a_q == IO_ID);
        is_out      = (ir_b_q == IO_ID);

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    mp_start = 1'b1;
                    mp_addr  = pc_q;
                    state_d  = ST_FA;
                end
            end
            ST_FA: begin
                if (mp_done) begin
                    ir_a_d   = mp_rdata;
                    mp_start = 1'b1;
                    mp_addr  = pc_q + ADDR_W'(1);
                    state_d  = ST_FB;
                end
            end
            ST_FB: begin
                if (mp_done) begin
                    ir_b_d   = mp_rdata;
                    mp_start = 1'b1;
                    mp_addr  = pc_q + ADDR_W'(2);
                    state_d  = ST_FC;
                end
            end
            ST_FC: begin
                if (mp_done) begin
                    ir_c_d = mp_rdata;
                    if (is_in) begin
                        in_ready_d = 1'b1;
                        state_d    = ST_IN_W;
                    end else begin
                        mp_start = 1'b1;
                        mp_addr  = ir_a_q[ADDR_W-1:0];
                        state_d  = ST_RA;
                    end
                end
            end
            ST_RA: begin
                if (mp_done) begin
                    a_d = mp_rdata;
                    if (is_out) begin
                        out_valid_d = 1'b1;
                        out_data_d  = mp_rdata[7:0];
                        state_d     = ST_OUT_W;
                    end else begin
                        mp_start = 1'b1;
                        mp_addr  = ir_b_q[ADDR_W-1:0];
                        state_d  = ST_RB;
                    end
                end
            end
            ST_RB: begin
                if (mp_done) begin
                    b_d     = mp_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                le_d     = diff[DATA_W-1] || (diff == '0);
                mp_start = 1'b1;
                mp_wr    = 1'b1;
                mp_addr  = ir_b_q[ADDR_W-1:0];
                mp_wdata = diff;
                state_d  = ST_WB;
            end
            ST_IN_W: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    mp_start   = 1'b1;
                    mp_wr      = 1'b1;
                    mp_addr    = ir_b_q[ADDR_W-1:0];
                    mp_wdata   = DATA_W'(in_data);
                    state_d    = ST_WB;
                end
            end
            ST_WB: begin
                if (mp_done) begin
                    // Input instructions never branch; le_q is stale for them
                    if (is_in || !le_q) begin
                        pc_d    = pc_next;
                        state_d = ST_IDLE;
                    end else if (!ir_c_q[DATA_W-1]) begin
                        pc_d    = ir_c_q[ADDR_W-1:0];
                        state_d = ST_IDLE;
                    end else begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                end
            end
            ST_OUT_W: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_next;
                    state_d     = ST_IDLE;
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign in_ready  = in_ready_q;
    assign halted    = halted_q;
    assign pc_dbg    = pc_q;

endmodule
`default_nettype wire
